// File: rtl/first_match_arbiter.sv
// Round-robin front end sharing one first-match window checker among NREQ launchers.
// Each grant watches signal_in over [min_dly, max_dly] cycles and reports match, fail or abort.
module first_match_arbiter #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 8,
  parameter int ID_W  = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [CNT_W-1:0] min_dly,
  input  logic [CNT_W-1:0] max_dly,
  input  logic             signal_in,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic             fail,
  output logic             cfg_err,
  output logic             abort,
  output logic [ID_W-1:0]  done_id
);

  typedef enum logic [1:0] {IDLE, EVAL, REPORT} state_t;

  state_t           state;
  logic [ID_W-1:0]  ptr, cur_id, pick_id;
  logic             pick_vld;
  logic [CNT_W-1:0] cnt, min_q, max_q;
  logic             in_win;
  int               idx;

  // Walk downward from the farthest slot so the nearest set bit after ptr wins.
  always_comb begin
    pick_id  = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        pick_id  = ID_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign in_win = (cnt >= min_q) && (cnt <= max_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      match   <= 1'b0;
      fail    <= 1'b0;
      cfg_err <= 1'b0;
      abort   <= 1'b0;
      done_id <= '0;
      cnt     <= '0;
      min_q   <= '0;
      max_q   <= '0;
      cur_id  <= '0;
      ptr     <= ID_W'(NREQ - 1);
    end else begin
      done    <= 1'b0;
      match   <= 1'b0;
      fail    <= 1'b0;
      cfg_err <= 1'b0;
      abort   <= 1'b0;
      case (state)
        IDLE: if (pick_vld) begin
          state  <= EVAL;
          busy   <= 1'b1;
          gnt    <= NREQ'(1) << pick_id;
          cur_id <= pick_id;
          ptr    <= pick_id;
          min_q  <= min_dly;
          max_q  <= max_dly;
          cnt    <= '0;
        end
        EVAL: begin
          // A dropped request outranks any outcome decided in the same cycle.
          if (!req[cur_id]) begin
            state   <= IDLE;
            busy    <= 1'b0;
            gnt     <= '0;
            abort   <= 1'b1;
            done_id <= cur_id;
          end else if (max_q < min_q) begin
            state   <= REPORT;
            gnt     <= '0;
            done    <= 1'b1;
            fail    <= 1'b1;
            cfg_err <= 1'b1;
            done_id <= cur_id;
          end else if (in_win && signal_in) begin
            state   <= REPORT;
            gnt     <= '0;
            done    <= 1'b1;
            match   <= 1'b1;
            done_id <= cur_id;
          end else if (cnt == max_q) begin
            state   <= REPORT;
            gnt     <= '0;
            done    <= 1'b1;
            fail    <= 1'b1;
            done_id <= cur_id;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REPORT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_first_match_arbiter.sv
// Directed and randomized attempts checked against a transaction-level model of arbitration and windows.
module tb_first_match_arbiter;
  localparam int NREQ = 4;
  localparam int CNT_W = 8;
  localparam int ID_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NREQ-1:0]  req;
  logic [CNT_W-1:0] min_dly, max_dly;
  logic             signal_in;
  logic [NREQ-1:0]  gnt;
  logic             busy, done, match, fail, cfg_err, abort;
  logic [ID_W-1:0]  done_id;

  int errors = 0;
  int checks = 0;
  int last   = NREQ - 1;

  first_match_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .min_dly(min_dly), .max_dly(max_dly),
    .signal_in(signal_in), .gnt(gnt), .busy(busy), .done(done), .match(match),
    .fail(fail), .cfg_err(cfg_err), .abort(abort), .done_id(done_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic [NREQ-1:0] r, input int after);
    for (int k = 1; k <= NREQ; k++)
      if (r[(after + k) % NREQ]) return (after + k) % NREQ;
    return -1;
  endfunction

  // kind: 0 match, 1 fail, 2 cfg error, 3 abort
  task automatic attempt(input logic [NREQ-1:0] r, input int mn, input int mx,
                         input logic [255:0] sig, input int abort_at);
    int w, res, kind;
    logic [NREQ-1:0] oh;
    w = winner(r, last);
    oh = NREQ'(1) << w;
    if (mx < mn) begin
      res = 0; kind = 2;
    end else begin
      res = mx; kind = 1;
      for (int k = mn; k <= mx; k++)
        if (sig[k]) begin res = k; kind = 0; break; end
    end
    if (abort_at >= 0 && abort_at <= res) begin res = abort_at; kind = 3; end

    req = r; min_dly = CNT_W'(mn); max_dly = CNT_W'(mx); signal_in = 1'b0;
    tick();
    chk("grant", gnt, oh);
    chk("busy_eval", busy, 1);
    // Window bounds are latched; later changes must be ignored.
    min_dly = CNT_W'($urandom); max_dly = CNT_W'($urandom);
    for (int k = 0; k <= res; k++) begin
      signal_in = sig[k];
      if (kind == 3 && k == res) req[w] = 1'b0;
      tick();
      if (k < res) begin
        chk("no_done_early", {abort, done}, 0);
        chk("gnt_held", gnt, oh);
      end
    end
    if (kind == 3) begin
      chk("abort_pulse", {abort, done}, 2'b10);
      chk("abort_id", done_id, w);
      chk("abort_gnt", {busy, gnt}, 0);
    end else begin
      chk("done_flags", {abort, done, match, fail, cfg_err},
          {2'b01, kind == 0, kind != 0, kind == 2});
      chk("done_id", done_id, w);
      chk("done_gnt", gnt, 0);
    end
    last = w;
    req = '0; signal_in = 1'b0;
    tick();
    chk("settle_idle", {busy, gnt, done, abort, match, fail}, 0);
  endtask

  initial begin
    logic [255:0] s;
    int mn, mx, ab;
    logic [NREQ-1:0] r;
    rst_n = 1'b0; req = '0; min_dly = '0; max_dly = '0; signal_in = 1'b0;
    tick(); tick();
    chk("reset_outs", {gnt, busy, done, match, fail, cfg_err, abort, done_id}, 0);
    rst_n = 1'b1;

    // Held round-robin, zero-delay matches: ids 0,1,2,3,0.
    req = 4'b1111; min_dly = 0; max_dly = 0; signal_in = 1'b1;
    tick();
    chk("rr_gnt", gnt, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_done", {done, match, fail}, 3'b110);
      chk("rr_id", done_id, i % NREQ);
      chk("rr_gnt_drop", gnt, 0);
      tick();
      chk("rr_idle_gap", {busy, gnt}, 0);
      if (i < 4) begin
        tick();
        chk("rr_gnt", gnt, NREQ'(1) << ((i + 1) % NREQ));
      end
    end
    req = '0; signal_in = 1'b0; last = 0;
    tick();

    s = '0; s[1] = 1'b1; s[3] = 1'b1;
    attempt(4'b0100, 2, 5, s, -1);
    attempt(4'b0001, 1, 3, '0, -1);
    s = '0; s[0] = 1'b1;
    attempt(4'b0010, 0, 0, s, -1);
    attempt(4'b0010, 0, 0, '0, -1);
    attempt(4'b1000, 5, 2, s, -1);
    attempt(4'b0010, 0, 10, '0, 4);
    s = '0; s[254] = 1'b1; s[10] = 1'b1;
    attempt(4'b0001, 250, 255, s, -1);
    attempt(4'b0001, 255, 255, '0, -1);

    // Reset in mid-evaluation discards the attempt and restores id 0 priority.
    req = 4'b0010; min_dly = 0; max_dly = 10; signal_in = 1'b0;
    tick();
    chk("rst_pre_gnt", gnt, NREQ'(1) << winner(4'b0010, last));
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mid_outs", {gnt, busy, done, match, fail, cfg_err, abort, done_id}, 0);
    rst_n = 1'b1; req = '0; last = NREQ - 1;
    tick();
    chk("rst_no_pulse", {done, abort, busy}, 0);
    s = '0; s[0] = 1'b1;
    attempt(4'b1111, 0, 0, s, -1);

    for (int n = 0; n < 40; n++) begin
      r = NREQ'($urandom_range(1, 15));
      mn = $urandom_range(0, 8);
      mx = $urandom_range(0, 10);
      s = '0;
      for (int k = 0; k < 16; k++) s[k] = ($urandom_range(0, 4) == 0);
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 10) : -1;
      attempt(r, mn, mx, s, ab);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
